filter_tile_scheduler: RTL and testbench

Controls which video filter appears in each tile of the 3x3 preview grid drawn in the 320x240 image window. It debounces the user pushbuttons, keeps a rotation offset that maps grid tiles to filter IDs, and optionally auto-rotates. Rotation changes commit only at the frame boundary. Its registered `filter_sel` output drives the per-pixel filter datapath in the 25 MHz VGA pixel domain.

---
 rtl/filter_tile_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_filter_tile_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_tile_scheduler.sv
// filter_tile_scheduler: maps the 3x3 preview grid to filter IDs through a rotation
// offset committed at the frame boundary. Define FILTER_SCHED_AUTO_EN to build in auto-rotate.
module filter_tile_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic [9:0] hcounter,
  input  logic [9:0] vcounter,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_auto,
  output logic [3:0] filter_sel,
  output logic [3:0] tile_idx,
  output logic       in_image,
  output logic [3:0] offset,
  output logic       auto_active,
  output logic       frame_tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef FILTER_SCHED_AUTO_EN
  localparam int NB = 3;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_auto, btn_prev, btn_next};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn_raw;
  logic          auto_btn_unused;
  assign btn_raw         = {btn_prev, btn_next};
  assign auto_btn_unused = btn_auto;
`endif

  logic [NB-1:0] press;

  // Per-button synchronizer and debounce; press[] is high the cycle the stable level rises.
  for (genvar gi = 0; gi < NB; gi++) begin : g_deb
    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[1] != stable_q) begin
        if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = ~stable_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign press[gi] = stable_d & ~stable_q;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
        sync_q   <= '0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync_q   <= {sync_q[0], btn_raw[gi]};
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  typedef enum logic [1:0] {PEND_NONE, PEND_FWD, PEND_BACK} pend_e;
  pend_e pend_q, pend_d;

  logic commit;
  assign commit = (hcounter == 10'd0) && (vcounter == 10'd0);

  always_comb begin
    pend_d = pend_q;
    if (commit) begin
      pend_d = PEND_NONE;
    end else if (press[0] && press[1]) begin
      pend_d = PEND_NONE;
    end else if (press[0]) begin
      pend_d = PEND_FWD;
    end else if (press[1]) begin
      pend_d = PEND_BACK;
    end
  end

  function automatic logic [3:0] inc9(input logic [3:0] v);
    return (v == 4'd8) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] dec9(input logic [3:0] v);
    return (v == 4'd0) ? 4'd8 : v - 4'd1;
  endfunction

  logic auto_step;

`ifdef FILTER_SCHED_AUTO_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  logic          auto_q, auto_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // A manual request at the auto edge takes precedence but still restarts the frame count.
  always_comb begin
    auto_d    = auto_q ^ press[2];
    fcnt_d    = fcnt_q;
    auto_step = 1'b0;
    if (!auto_d) begin
      fcnt_d = '0;
    end else if (commit && auto_q) begin
      if (fcnt_q == FW'(AUTO_FRAMES - 1)) begin
        fcnt_d    = '0;
        auto_step = (pend_q == PEND_NONE);
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      auto_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      auto_q <= auto_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign auto_active = auto_q;
`else
  assign auto_step   = 1'b0;
  assign auto_active = 1'b0;
`endif

  logic [3:0] offset_q, offset_d;
  logic       frame_tick_q, frame_tick_d;

  always_comb begin
    offset_d     = offset_q;
    frame_tick_d = commit;
    if (commit) begin
      case (pend_q)
        PEND_FWD:  offset_d = inc9(offset_q);
        PEND_BACK: offset_d = dec9(offset_q);
        default:   if (auto_step) offset_d = inc9(offset_q);
      endcase
    end
  end

  logic [3:0] filter_q, filter_d;
  logic [3:0] tile_q, tile_d;
  logic       in_image_q, in_image_d;
  logic [1:0] col, row;
  logic [3:0] tile_n, base;
  logic [4:0] sum;

  always_comb begin
    in_image_d = (hcounter >= 10'd160) && (hcounter <= 10'd479) &&
                 (vcounter >= 10'd120) && (vcounter <= 10'd359);
    if (hcounter <= 10'd266)      col = 2'd0;
    else if (hcounter <= 10'd373) col = 2'd1;
    else                          col = 2'd2;
    if (vcounter <= 10'd199)      row = 2'd0;
    else if (vcounter <= 10'd279) row = 2'd1;
    else                          row = 2'd2;
    tile_n = {2'b00, row} + {1'b0, row, 1'b0} + {2'b00, col};
    case (tile_n)
      4'd5:    base = 4'd8;
      4'd6:    base = 4'd5;
      4'd7:    base = 4'd6;
      4'd8:    base = 4'd7;
      default: base = tile_n;
    endcase
    // Both operands are below 9, so one conditional subtract yields the mod-9 result.
    sum = {1'b0, base} + {1'b0, offset_q};
    if (sum >= 5'd9) sum = sum - 5'd9;
    tile_d   = in_image_d ? tile_n   : 4'hF;
    filter_d = in_image_d ? sum[3:0] : 4'hF;
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= PEND_NONE;
      offset_q     <= 4'd0;
      frame_tick_q <= 1'b0;
      filter_q     <= 4'hF;
      tile_q       <= 4'hF;
      in_image_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      offset_q     <= offset_d;
      frame_tick_q <= frame_tick_d;
      filter_q     <= filter_d;
      tile_q       <= tile_d;
      in_image_q   <= in_image_d;
    end
  end

  assign filter_sel = filter_q;
  assign tile_idx   = tile_q;
  assign in_image   = in_image_q;
  assign offset     = offset_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_filter_tile_scheduler.sv
// Self-checking bench for filter_tile_scheduler: an abstract model of tile mapping,
// pending requests and frame commits, checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_filter_tile_scheduler;
  localparam int DEB = 4;
  localparam int AF  = 2;
  localparam int EV_FWD = 1, EV_BACK = 2, EV_BOTH = 3, EV_AUTO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hc = 10'd300;
  logic [9:0] vc = 10'd250;
  logic       btn_next = 1'b0, btn_prev = 1'b0, btn_auto = 1'b0;
  logic [3:0] filter_sel, tile_idx, offset;
  logic       in_image, auto_active, frame_tick;

  always #20 clk = ~clk;

  filter_tile_scheduler #(.DEBOUNCE_CYCLES(DEB), .AUTO_FRAMES(AF)) dut (
    .clk_25mhz(clk), .rst_n(rst_n), .hcounter(hc), .vcounter(vc),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_auto(btn_auto),
    .filter_sel(filter_sel), .tile_idx(tile_idx), .in_image(in_image),
    .offset(offset), .auto_active(auto_active), .frame_tick(frame_tick)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  int base_map [9] = '{0, 1, 2, 3, 4, 8, 5, 6, 7};
  int m_offset = 0, m_pend = 0, m_auto = 0, m_fcnt = 0;
  int exp_filter = 15, exp_tile = 15, exp_in = 0, exp_tick = 0;
  int ev_seq = 0, ev_code = 0, seen_seq = 0;
  int col, row, tile;
  logic busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_offset = 0; m_pend = 0; m_auto = 0; m_fcnt = 0;
      exp_filter = 15; exp_tile = 15; exp_in = 0; exp_tick = 0;
      seen_seq = ev_seq;
    end else begin
      if (hc >= 160 && hc < 480 && vc >= 120 && vc < 360) begin
        col = (int'(hc) - 160) / 107;
        row = (int'(vc) - 120) / 80;
        tile = row * 3 + col;
        exp_in = 1; exp_tile = tile;
        exp_filter = (base_map[tile] + m_offset) % 9;
      end else begin
        exp_in = 0; exp_tile = 15; exp_filter = 15;
      end
      exp_tick = (hc == 0 && vc == 0) ? 1 : 0;
      if (exp_tick == 1) begin
        if (m_pend == 1) m_offset = (m_offset + 1) % 9;
        else if (m_pend == 2) m_offset = (m_offset + 8) % 9;
        if (m_auto == 1) begin
          m_fcnt++;
          if (m_fcnt == AF) begin
            m_fcnt = 0;
            if (m_pend == 0) m_offset = (m_offset + 1) % 9;
          end
        end
        m_pend = 0;
      end else if (ev_seq != seen_seq) begin
        seen_seq = ev_seq;
        case (ev_code)
          EV_FWD:  m_pend = 1;
          EV_BACK: m_pend = 2;
          EV_BOTH: m_pend = 0;
          default: begin
`ifdef FILTER_SCHED_AUTO_EN
            m_auto = 1 - m_auto;
            m_fcnt = 0;
`endif
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("in_image", int'(in_image), exp_in);
    check("tile_idx", int'(tile_idx), exp_tile);
    check("filter_sel", int'(filter_sel), exp_filter);
    check("offset", int'(offset), m_offset);
    check("frame_tick", int'(frame_tick), exp_tick);
    if (!busy) check("auto_active", int'(auto_active), m_auto);
  end

  int pix_k = 0;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_k++;
      hc = 10'(140 + (pix_k * 37) % 360);
      vc = 10'(100 + (pix_k * 23) % 280);
    end
  endtask

  task automatic drive_px(input int h, input int v);
    @(negedge clk);
    hc = 10'(h); vc = 10'(v);
    @(negedge clk);
  endtask

  task automatic press(input int code);
    busy = 1'b1;
    @(negedge clk);
    btn_next = (code == EV_FWD || code == EV_BOTH);
    btn_prev = (code == EV_BACK || code == EV_BOTH);
    btn_auto = (code == EV_AUTO);
    tick(10);
    @(negedge clk);
    btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
    tick(10);
    ev_code = code;
    ev_seq++;
    tick(2);
    busy = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    hc = 10'd0; vc = 10'd0;
    tick(1);
  endtask

  initial begin
    tick(4);
    check("rst_filter_sel", int'(filter_sel), 15);
    check("rst_tile_idx", int'(tile_idx), 15);
    check("rst_in_image", int'(in_image), 0);
    check("rst_offset", int'(offset), 0);
    check("rst_auto", int'(auto_active), 0);
    check("rst_tick", int'(frame_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive_px(160, 120);
    check("px160_120_tile", int'(tile_idx), 0);
    check("px160_120_filter", int'(filter_sel), 0);
    check("px160_120_in", int'(in_image), 1);
    drive_px(479, 200);
    check("px479_200_tile", int'(tile_idx), 5);
    check("px479_200_filter", int'(filter_sel), 8);
    drive_px(480, 200);
    check("px480_filter", int'(filter_sel), 15);
    check("px480_in", int'(in_image), 0);

    press(EV_FWD);
    check("fwd_before_commit", int'(offset), 0);
    frame();
    check("fwd_offset", int'(offset), 1);
    check("fwd_tick_high", int'(frame_tick), 1);
    tick(1);
    check("fwd_tick_low", int'(frame_tick), 0);
    drive_px(479, 200);
    check("tile5_wrap_filter", int'(filter_sel), 0);
    for (int i = 0; i < 8; i++) begin
      press(EV_FWD);
      frame();
    end
    check("nine_steps_offset", int'(offset), 0);

    press(EV_BACK);
    frame();
    check("back_wrap_offset", int'(offset), 8);

    @(negedge clk);
    btn_next = 1'b1;
    tick(2);
    @(negedge clk);
    btn_next = 1'b0;
    tick(10);
    frame();
    check("glitch_offset", int'(offset), 8);

    press(EV_FWD);
    press(EV_BOTH);
    frame();
    check("both_offset", int'(offset), 8);

`ifdef FILTER_SCHED_AUTO_EN
    press(EV_AUTO);
    check("auto_on", int'(auto_active), 1);
    frame(); check("auto_f1", int'(offset), 8);
    frame(); check("auto_f2", int'(offset), 0);
    frame(); check("auto_f3", int'(offset), 0);
    frame(); check("auto_f4", int'(offset), 1);
    frame(); check("auto_f5", int'(offset), 1);
    press(EV_FWD);
    frame(); check("auto_manual_wins", int'(offset), 2);
    frame(); check("auto_f7", int'(offset), 2);
    frame(); check("auto_f8", int'(offset), 3);
`else
    press(EV_AUTO);
    check("auto_disabled", int'(auto_active), 0);
    for (int i = 0; i < 5; i++) frame();
    check("auto_disabled_offset", int'(offset), 8);
`endif

    for (int i = 0; i < 9 && m_offset != 4; i++) begin
      press(EV_FWD);
      frame();
    end
    check("pre_reset_offset", int'(offset), 4);
    press(EV_FWD);
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_offset", int'(offset), 0);
    check("midrst_filter", int'(filter_sel), 15);
    check("midrst_tile", int'(tile_idx), 15);
    check("midrst_in", int'(in_image), 0);
    check("midrst_auto", int'(auto_active), 0);
    check("midrst_tick", int'(frame_tick), 0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    frame();
    check("post_rst_offset", int'(offset), 0);
    check("post_rst_tick", int'(frame_tick), 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
